alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_opcodes_pkg.sv | 45 ++++
 rtl/alu_riscv.sv | 62 ++++++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_opcodes_pkg.sv
// Shared ALU definitions: opcode constants, data widths, arbiter FSM state
// and the captured-request payload.
package alu_opcodes_pkg;

  localparam int unsigned ALU_OP_W   = 5;
  localparam int unsigned ALU_DATA_W = 32;

  // Arithmetic / logic
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'h00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'h01;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'h02;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'h03;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'h04;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'h05;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'h06;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'h07;
  // Comparisons: flag carries the outcome, result is the zero-extended flag
  localparam logic [ALU_OP_W-1:0] ALU_LTS  = 5'h08;
  localparam logic [ALU_OP_W-1:0] ALU_LTU  = 5'h09;
  localparam logic [ALU_OP_W-1:0] ALU_GES  = 5'h0A;
  localparam logic [ALU_OP_W-1:0] ALU_GEU  = 5'h0B;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 5'h0C;
  localparam logic [ALU_OP_W-1:0] ALU_NE   = 5'h0D;
  // Signed min / max
  localparam logic [ALU_OP_W-1:0] ALU_MIN  = 5'h0E;
  localparam logic [ALU_OP_W-1:0] ALU_MAX  = 5'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
  } alu_req_t;

  // True for the opcodes whose result is the comparison flag.
  function automatic logic is_cmp_op(input logic [ALU_OP_W-1:0] op);
    return (op >= ALU_LTS) && (op <= ALU_NE);
  endfunction

endpackage

// File: rtl/alu_riscv.sv
// Combinational 32-bit ALU.
// Ports: operator_i (opcode), operand_a_i / operand_b_i (operands),
//        result_c_o (result), flag_c_o (comparison flag).
// Undefined opcodes return result 0 and flag 0.
module alu_riscv
  import alu_opcodes_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   operator_i,
  input  logic [ALU_DATA_W-1:0] operand_a_i,
  input  logic [ALU_DATA_W-1:0] operand_b_i,
  output logic [ALU_DATA_W-1:0] result_c_o,
  output logic                  flag_c_o
);

  logic [4:0] shamt;
  logic       lts;
  logic       ltu;
  logic       eq;
  logic       cmp_flag;

  assign shamt = operand_b_i[4:0];
  assign lts   = $signed(operand_a_i) < $signed(operand_b_i);
  assign ltu   = operand_a_i < operand_b_i;
  assign eq    = operand_a_i == operand_b_i;

  // Comparison outcome, zero for non-comparison opcodes
  always_comb begin : cmp_sel
    cmp_flag = 1'b0;
    case (operator_i)
      ALU_LTS: cmp_flag = lts;
      ALU_LTU: cmp_flag = ltu;
      ALU_GES: cmp_flag = ~lts;
      ALU_GEU: cmp_flag = ~ltu;
      ALU_EQ:  cmp_flag = eq;
      ALU_NE:  cmp_flag = ~eq;
      default: cmp_flag = 1'b0;
    endcase
  end

  // Result mux
  always_comb begin : res_sel
    result_c_o = '0;
    flag_c_o   = cmp_flag;
    case (operator_i)
      ALU_ADD: result_c_o = operand_a_i + operand_b_i;
      ALU_SUB: result_c_o = operand_a_i - operand_b_i;
      ALU_AND: result_c_o = operand_a_i & operand_b_i;
      ALU_OR:  result_c_o = operand_a_i | operand_b_i;
      ALU_XOR: result_c_o = operand_a_i ^ operand_b_i;
      ALU_SLL: result_c_o = operand_a_i << shamt;
      ALU_SRL: result_c_o = operand_a_i >> shamt;
      ALU_SRA: result_c_o = ALU_DATA_W'($signed(operand_a_i) >>> shamt);
      ALU_MIN: result_c_o = lts ? operand_a_i : operand_b_i;
      ALU_MAX: result_c_o = lts ? operand_b_i : operand_a_i;
      default: result_c_o = '0;
    endcase
    if (is_cmp_op(operator_i)) begin
      result_c_o = ALU_DATA_W'(cmp_flag);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, one operation
// in flight at a time (IDLE -> EXEC -> RESP).
// Ports: CLK100 / resetn (sync, active-low); req_valid_i / req_ready_o with
//        packed req_op_i, req_a_i, req_b_i per requester; rsp_valid_o /
//        rsp_ready_i per requester with shared rsp_result_o / rsp_flag_o;
//        busy_o high whenever not IDLE.
module alu_arbiter
  import alu_opcodes_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                       CLK100,
  input  logic                       resetn,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [ALU_OP_W*NREQ-1:0]   req_op_i,
  input  logic [ALU_DATA_W*NREQ-1:0] req_a_i,
  input  logic [ALU_DATA_W*NREQ-1:0] req_b_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  input  logic [NREQ-1:0]            rsp_ready_i,
  output logic [ALU_DATA_W-1:0]      rsp_result_o,
  output logic                       rsp_flag_o,
  output logic                       busy_o
);

  localparam int unsigned GNT_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e            state_q, state_d;
  logic [GNT_W-1:0]      last_grant_q, last_grant_d;
  logic [GNT_W-1:0]      gnt_id_q, gnt_id_d;
  alu_req_t              cap_q, cap_d;
  logic [ALU_DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_flag_q, rsp_flag_d;
  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;

  logic                  pick_found;
  logic [GNT_W-1:0]      pick_id;
  int unsigned           pick_sel;
  logic [ALU_DATA_W-1:0] alu_result_c;
  logic                  alu_flag_c;

  // ALU sees only the captured operands, never the live request buses
  alu_riscv u_alu (
    .operator_i  (cap_q.op),
    .operand_a_i (cap_q.a),
    .operand_b_i (cap_q.b),
    .result_c_o  (alu_result_c),
    .flag_c_o    (alu_flag_c)
  );

  // Round-robin search starting just above the last grant, with wrap
  always_comb begin : rr_pick
    logic [GNT_W-1:0] idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = GNT_W'((32'(last_grant_q) + i) % NREQ);
      if (!pick_found && req_valid_i[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign pick_sel = 32'(pick_id);

  // State register
  always_ff @(posedge CLK100) begin : state_reg
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_W'(NREQ - 1);
      gnt_id_q     <= '0;
      cap_q        <= '0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      cap_q        <= cap_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and outputs
  always_comb begin : fsm_next
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    cap_d        = cap_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          req_ready_o[pick_id] = 1'b1;
          cap_d.op     = req_op_i[pick_sel*ALU_OP_W +: ALU_OP_W];
          cap_d.a      = req_a_i[pick_sel*ALU_DATA_W +: ALU_DATA_W];
          cap_d.b      = req_b_i[pick_sel*ALU_DATA_W +: ALU_DATA_W];
          gnt_id_d     = pick_id;
          last_grant_d = pick_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result_c;
        rsp_flag_d   = alu_flag_c;
        rsp_valid_d  = NREQ'(1) << gnt_id_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Only the active requester's ready closes the response
        if (rsp_ready_i[gnt_id_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flag_o   = rsp_flag_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the stimulus process predicts grants and
// ALU results and queues expected responses; the monitor checks them.
module tb_alu_arbiter;
  import alu_opcodes_pkg::*;

  localparam int NREQ = 2;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [5*NREQ-1:0]      req_op_i;
  logic [32*NREQ-1:0]     req_a_i;
  logic [32*NREQ-1:0]     req_b_i;
  logic [NREQ-1:0]        rsp_valid_o;
  logic [NREQ-1:0]        rsp_ready_i;
  logic [31:0]            rsp_result_o;
  logic                   rsp_flag_o;
  logic                   busy_o;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .CLK100       (clk),
    .resetn       (resetn),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_flag_o   (rsp_flag_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        flag;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   hs_count = 0;
  int   hs_seen = 0;

  // Reference model state
  logic [NREQ-1:0] pend = '0;
  logic [4:0]      p_op [NREQ];
  logic [31:0]     p_a  [NREQ];
  logic [31:0]     p_b  [NREQ];
  int              last = NREQ - 1;
  bit              inflight = 0;
  int              refill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic f);
    int sa, sb_;
    sa = a; sb_ = b;
    r = 32'd0; f = 1'b0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      ALU_SRA: r = 32'(sa >>> b[4:0]);
      ALU_LTS: f = sa < sb_;
      ALU_LTU: f = a < b;
      ALU_GES: f = sa >= sb_;
      ALU_GEU: f = a >= b;
      ALU_EQ:  f = a == b;
      ALU_NE:  f = a != b;
      ALU_MIN: r = (sa < sb_) ? a : b;
      ALU_MAX: r = (sa < sb_) ? b : a;
      default: begin r = 32'd0; f = 1'b0; end
    endcase
    if (op >= ALU_LTS && op <= ALU_NE) r = {31'd0, f};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int lg);
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (lg + i) % NREQ;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic load(input int k, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[k] = 1'b1; p_op[k] = op; p_a[k] = a; p_b[k] = b;
  endtask

  task automatic load_rand(input int k);
    logic [31:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    load(k, 5'($urandom_range(0, 19)), a, b);
  endtask

  // One cycle: drive requests, check grant against the model, queue response
  task automatic step(input bit drop, input bit rnd);
    logic [NREQ-1:0] v;
    int g;
    exp_t e;
    @(negedge clk);
    if (rnd) for (int k = 0; k < NREQ; k++)
      if (!pend[k] && $urandom_range(0, 3) == 0) load_rand(k);
    for (int k = 0; k < NREQ; k++) begin
      v[k] = pend[k] && !(drop && $urandom_range(0, 5) == 0);
      req_op_i[k*5 +: 5]  = v[k] ? p_op[k] : 5'($urandom);
      req_a_i[k*32 +: 32] = v[k] ? p_a[k]  : $urandom;
      req_b_i[k*32 +: 32] = v[k] ? p_b[k]  : $urandom;
    end
    req_valid_i = v;
    #2;
    if (hs_count != hs_seen) begin hs_seen = hs_count; inflight = 0; end
    g = (!inflight && |v) ? pick(v, last) : -1;
    chk("busy", {31'd0, busy_o}, {31'd0, inflight});
    chk("grant", {{(32-NREQ){1'b0}}, req_ready_o}, (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      ref_alu(p_op[g], p_a[g], p_b[g], e.res, e.flag);
      e.id = g; e.t = cyc;
      sb.push_back(e);
      last = g; inflight = 1; pend[g] = 1'b0;
      if (refill > 0) begin load_rand(g); refill--; end
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((inflight || sb.size() != 0 || |pend) && n < maxc) begin step(0, 0); n++; end
    if (n >= maxc) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: still busy after %0d cycles, queue %0d expected 0", n, sb.size());
    end
  endtask

  // Monitor: check each response on arrival, hold it under backpressure
  initial begin : monitor
    exp_t e;
    bit   active;
    int   stall;
    int   nresp;
    active = 0; stall = 0; nresp = 0;
    rsp_ready_i = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        active = 0;
        #1 rsp_ready_i = '0;
        continue;
      end
      if (rsp_valid_o != '0) begin
        if (!active) begin
          if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL rsp_unexpected: got valid %b expected no response", rsp_valid_o);
          end else begin
            e = sb.pop_front();
            chk("rsp_valid", {{(32-NREQ){1'b0}}, rsp_valid_o}, 32'd1 << e.id);
            chk("rsp_result", rsp_result_o, e.res);
            chk("rsp_flag", {31'd0, rsp_flag_o}, {31'd0, e.flag});
            chk("rsp_latency", 32'(cyc), 32'(e.t + 2));
            active = 1;
            stall = (nresp == 0) ? 5 : $urandom_range(0, 3);
            nresp++;
          end
        end else begin
          chk("hold_valid", {{(32-NREQ){1'b0}}, rsp_valid_o}, 32'd1 << e.id);
          chk("hold_result", rsp_result_o, e.res);
          chk("hold_flag", {31'd0, rsp_flag_o}, {31'd0, e.flag});
          chk("hold_busy", {31'd0, busy_o}, 32'd1);
        end
      end else if (active) begin
        n_chk++; n_err++;
        $display("FAIL rsp_dropped: got valid 0 expected %0d held", e.id);
        active = 0;
      end
      #1;
      if (active) begin
        if (stall > 0) begin
          rsp_ready_i = NREQ'($urandom) & ~(NREQ'(1) << e.id);
          stall--;
        end else begin
          rsp_ready_i = (NREQ'(1) << e.id) | NREQ'($urandom);
          active = 0;
          hs_count++;
        end
      end else begin
        rsp_ready_i = NREQ'($urandom);
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    resetn = 1'b0;
    req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_ready", {{(32-NREQ){1'b0}}, req_ready_o}, 32'd0);
    chk("rst_rsp_valid", {{(32-NREQ){1'b0}}, rsp_valid_o}, 32'd0);
    chk("rst_result", rsp_result_o, 32'd0);
    chk("rst_flag", {31'd0, rsp_flag_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    resetn = 1'b1;

    // Single request
    load(0, ALU_ADD, 32'd5, 32'd7);
    drain(50);

    // Contention: both held valid, granted requester reloaded each time
    load(0, ALU_ADD, 32'd1, 32'd2);
    load(1, ALU_SUB, 32'd3, 32'd10);
    refill = 4;
    drain(100);

    // Flag ops
    load(0, ALU_LTS, 32'hFFFF_FFFF, 32'd1);
    drain(50);
    load(1, ALU_GES, 32'hFFFF_FFFF, 32'd1);
    drain(50);

    // Reset while the granted operation is in EXEC
    load(0, ALU_XOR, 32'h1234, 32'h00FF);
    load(1, ALU_OR, 32'h0F00, 32'h00F0);
    step(0, 0);
    chk("pre_reset_grant", {31'd0, inflight}, 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    req_valid_i = '0;
    #2;
    @(negedge clk);
    resetn = 1'b1;
    #2;
    chk("exec_rst_ready", {{(32-NREQ){1'b0}}, req_ready_o}, 32'd0);
    chk("exec_rst_valid", {{(32-NREQ){1'b0}}, rsp_valid_o}, 32'd0);
    chk("exec_rst_result", rsp_result_o, 32'd0);
    chk("exec_rst_flag", {31'd0, rsp_flag_o}, 32'd0);
    chk("exec_rst_busy", {31'd0, busy_o}, 32'd0);
    e = sb.pop_back();
    pend[e.id] = 1'b1;
    inflight = 0;
    last = NREQ - 1;
    drain(100);

    // Randomized traffic with requests dropping before grant
    for (int i = 0; i < 400; i++) step(1, 1);
    drain(200);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
